count_seg_display: RTL and testbench



---
 rtl/count_seg_display.sv | 181 ++++++++++++++++++
 tb/tb_count_seg_display.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/count_seg_display.sv
// count_seg_display
//   Consumes the 8-bit counter value and its skip_to_five flag. Converts the
//   count to three BCD digits with a sequential double-dabble engine, drives a
//   3-digit common-anode seven-segment display (time-multiplexed, leading-zero
//   blanking) and stretches the skip flag into a visible LED pulse.
//
// Ports
//   clk        system clock, rising edge
//   rstn       synchronous active-low reset
//   count_in   binary count from the counter stage
//   skip_in    skip_to_five flag from the counter stage
//   bcd_hund   hundreds digit (0..2)
//   bcd_tens   tens digit
//   bcd_ones   units digit
//   conv_busy  high while a conversion is running
//   seg_n      segments {g,f,e,d,c,b,a}, active-low
//   an_n       digit enables {hund,tens,ones}, active-low, one-cold
//   skip_led   stretched skip indicator, active-high
//
// Conversion FSM
//   state | meaning
//   IDLE  | compare count_in with last converted value, capture on change
//   SHIFT | 8 add-3/shift steps of double dabble
//   DONE  | publish scratch digits to bcd_*
module count_seg_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int STRETCH     = 5000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] count_in,
  input  logic       skip_in,
  output logic [3:0] bcd_hund,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       conv_busy,
  output logic [6:0] seg_n,
  output logic [2:0] an_n,
  output logic       skip_led
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = $clog2(STRETCH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  last_val;
  logic [7:0]  shadow;
  logic [11:0] scratch;
  logic [3:0]  bit_cnt;
  logic [19:0] shift_vec;

  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    shift_vec = {dd_adjust(scratch), shadow};
    case (state)
      IDLE:    if (count_in != last_val) state_nx = SHIFT;
      // bit_cnt reaches 8 on this edge
      SHIFT:   if (bit_cnt == 4'd7) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_val  <= '0;
      shadow    <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      bcd_hund  <= '0;
      bcd_tens  <= '0;
      bcd_ones  <= '0;
      conv_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count_in != last_val) begin
            shadow    <= count_in;
            last_val  <= count_in;
            scratch   <= '0;
            bit_cnt   <= '0;
            conv_busy <= 1'b1;
          end
        end
        SHIFT: begin
          {scratch, shadow} <= {shift_vec[18:0], 1'b0};
          bit_cnt           <= bit_cnt + 4'd1;
        end
        DONE: begin
          bcd_hund  <= scratch[11:8];
          bcd_tens  <= scratch[7:4];
          bcd_ones  <= scratch[3:0];
          conv_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Display mux: digit_sel 0=ones, 1=tens, 2=hund
  logic [RW-1:0] refresh_cnt;
  logic [1:0]    digit_sel;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      refresh_cnt <= '0;
      digit_sel   <= 2'd0;
      an_n        <= 3'b110;
    end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      case (digit_sel)
        2'd0:    begin digit_sel <= 2'd1; an_n <= 3'b101; end
        2'd1:    begin digit_sel <= 2'd2; an_n <= 3'b011; end
        default: begin digit_sel <= 2'd0; an_n <= 3'b110; end
      endcase
    end else begin
      refresh_cnt <= refresh_cnt + RW'(1);
    end
  end

  always_comb begin
    seg_n = seg_of(bcd_ones);
    case (digit_sel)
      2'd1:    seg_n = (bcd_hund == 4'd0 && bcd_tens == 4'd0) ? 7'h7F : seg_of(bcd_tens);
      2'd2:    seg_n = (bcd_hund == 4'd0) ? 7'h7F : seg_of(bcd_hund);
      default: seg_n = seg_of(bcd_ones);
    endcase
  end

  // skip_led registers (next counter != 0) so it tracks the counter exactly
  logic [SW-1:0] stretch_cnt, stretch_nx;

  always_comb begin
    stretch_nx = stretch_cnt;
    if (skip_in)                 stretch_nx = SW'(STRETCH);
    else if (stretch_cnt != '0)  stretch_nx = stretch_cnt - SW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stretch_cnt <= '0;
      skip_led    <= 1'b0;
    end else begin
      stretch_cnt <= stretch_nx;
      skip_led    <= (stretch_nx != '0);
    end
  end

endmodule

// File: tb/tb_count_seg_display.sv
// tb_count_seg_display
//   Scoreboard bench for count_seg_display with REFRESH_DIV=4, STRETCH=6.
//   A reference process at each rising edge predicts conversions from the
//   arithmetic value of count_in and pushes expected digits; a monitor at
//   each falling edge pops them when conv_busy drops and checks the display
//   mux, blanking, busy and skip LED against cycle-level expectations.
module tb_count_seg_display;

  localparam int RDIV = 4;
  localparam int STR  = 6;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] count_in = 8'd77;
  logic       skip_in = 1'b1;
  logic [3:0] bcd_hund, bcd_tens, bcd_ones;
  logic       conv_busy;
  logic [6:0] seg_n;
  logic [2:0] an_n;
  logic       skip_led;

  count_seg_display #(.REFRESH_DIV(RDIV), .STRETCH(STR)) dut (
    .clk(clk), .rstn(rstn), .count_in(count_in), .skip_in(skip_in),
    .bcd_hund(bcd_hund), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .conv_busy(conv_busy), .seg_n(seg_n), .an_n(an_n), .skip_led(skip_led)
  );

  always #5 clk = ~clk;

  typedef struct {int h; int t; int o; longint due;} exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  logic [6:0] lut [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000};

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  longint n = 0;
  longint k = 0;
  int     rem = 0;
  int     last = 0;
  bit     rst_edge = 0;
  bit     started = 0;
  bit     have_skip = 0;
  longint last_skip = 0;

  always @(posedge clk) begin
    n++;
    if (!rstn) begin
      started = 1;
      rst_edge = 1;
      rem = 0;
      last = 0;
      k = 0;
      have_skip = 0;
      q.delete();
    end else begin
      int v;
      rst_edge = 0;
      k++;
      if (skip_in) begin
        have_skip = 1;
        last_skip = n;
      end
      v = int'(count_in);
      if (rem > 0) rem--;
      else if (v != last) begin
        exp_t e;
        last = v;
        e.h = v / 100;
        e.t = (v / 10) % 10;
        e.o = v % 10;
        e.due = n + 9;
        q.push_back(e);
        rem = 9;
      end
    end
  end

  // monitor
  int shown_h = 0, shown_t = 0, shown_o = 0;
  bit prev_busy = 0;

  function automatic int exp_seg(int sel, int h, int t, int o);
    if (sel == 0) return int'(lut[o]);
    if (sel == 1) return (h == 0 && t == 0) ? 'h7F : int'(lut[t]);
    return (h == 0) ? 'h7F : int'(lut[h]);
  endfunction

  always @(negedge clk) begin
    if (started) begin
      int sel;
      if (rst_edge) begin
        shown_h = 0; shown_t = 0; shown_o = 0;
      end else if (prev_busy && !conv_busy) begin
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("done_cycle", n, e.due);
          check("bcd_result", {bcd_hund, bcd_tens, bcd_ones}, (e.h << 8) | (e.t << 4) | e.o);
          shown_h = e.h; shown_t = e.t; shown_o = e.o;
        end
      end
      if (q.size() > 0 && n > q[0].due + 1) begin
        check("conv_timeout", n, q[0].due);
        void'(q.pop_front());
      end
      sel = int'((k / RDIV) % 3);
      check("bcd_hold", {bcd_hund, bcd_tens, bcd_ones}, (shown_h << 8) | (shown_t << 4) | shown_o);
      check("conv_busy", conv_busy, rem > 0);
      check("an_n", an_n, (sel == 0) ? 3'b110 : (sel == 1) ? 3'b101 : 3'b011);
      check("seg_n", seg_n, exp_seg(sel, shown_h, shown_t, shown_o));
      check("skip_led", skip_led, have_skip && (n - last_skip) < STR);
      prev_busy = conv_busy;
    end
  end

  task automatic step(input int c);
    repeat (c) @(negedge clk);
  endtask

  initial begin
    // reset with live inputs
    step(3);
    rstn = 1'b1;
    skip_in = 1'b0;
    step(12);
    // basic conversions
    count_in = 8'd123; step(12);
    count_in = 8'd255; step(12);
    count_in = 8'd0;   step(12);
    count_in = 8'd100; step(12);
    // mid-conversion change
    count_in = 8'd40;  step(3);
    count_in = 8'd41;  step(25);
    // blanking and mux
    count_in = 8'd7;   step(24);
    count_in = 8'd205; step(24);
    // skip stretch: single pulse, then retrigger inside stretch
    skip_in = 1'b1; step(1); skip_in = 1'b0; step(10);
    skip_in = 1'b1; step(1); skip_in = 1'b0; step(2);
    skip_in = 1'b1; step(1); skip_in = 1'b0; step(10);
    // reset mid-conversion
    count_in = 8'd200; step(5);
    rstn = 1'b0; step(1);
    rstn = 1'b1; step(15);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) count_in = 8'($urandom_range(0, 255));
      skip_in = ($urandom_range(0, 9) == 0);
      rstn = ($urandom_range(0, 149) != 0);
      step(1);
    end
    rstn = 1'b1;
    skip_in = 1'b0;
    step(20);
    check("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
